freq_meter: RTL



---
 rtl/freq_meter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Gated frequency counter: synchronises an asynchronous pin and counts its rising edges over a
// fixed window of sysclk cycles, latching each window's count with a one-cycle valid pulse.
module freq_meter #(
    parameter int unsigned SYS_CLK_FREQ = 204_000_000,
    parameter int unsigned GATE_CYCLES  = SYS_CLK_FREQ,
    parameter int unsigned COUNT_WIDTH  = $clog2(SYS_CLK_FREQ),
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   sig_in,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] freq_out,
    output logic                   freq_valid,
    output logic                   overflow,
    output logic                   gate_active
);

    localparam int unsigned GateW = $clog2(GATE_CYCLES);
    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StGate
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q;
    logic                   sync_out;
    logic                   sig_edge;

    logic [GateW-1:0]       gate_cnt_q, gate_cnt_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] freq_q, freq_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;

    logic                   gate_last;
    logic                   sat_inc;
    logic [COUNT_WIDTH-1:0] edge_sum;

    // Synchroniser and history reset high so a pin already high at reset is not seen as an edge.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sig_edge = sync_out & ~hist_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_out;
        end
    end

    // FSM: state register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign gate_last = (state_q == StGate) && (gate_cnt_q == GateLast);

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        gate_active = 1'b0;
        unique case (state_q)
            StIdle:  gate_active = 1'b0;
            StGate:  gate_active = 1'b1;
            default: gate_active = 1'b0;
        endcase
    end

    // Saturating increment shared by the running count and the end-of-window result.
    always_comb begin
        sat_inc  = sig_edge && (edge_cnt_q == '1);
        edge_sum = edge_cnt_q;
        if (sig_edge && !sat_inc) begin
            edge_sum = edge_cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (state_q == StGate) begin
            if (gate_last) begin
                // Counters clear here so a back-to-back window starts with no dead cycle.
                freq_d     = edge_sum;
                overflow_d = ovf_q | sat_inc;
                valid_d    = 1'b1;
            end else if (enable) begin
                gate_cnt_d = gate_cnt_q + GateW'(1);
                edge_cnt_d = edge_sum;
                ovf_d      = ovf_q | sat_inc;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign freq_out   = freq_q;
    assign overflow   = overflow_q;
    assign freq_valid = valid_q;

endmodule
